shiftreg_seq: RTL and testbench

Parametrised sequential shift register for the Booth datapath and its successors. Supports parallel load, single-step shifts, and self-timed burst shifts of N positions with busy/done handshaking. Provides logical, arithmetic and rotate modes plus a serial-out bit, so the controller can issue one command per Booth iteration instead of one strobe per bit. Optionally supports a 2-bit step for radix-4 Booth.

---
 rtl/shiftreg_pkg.sv | 16 +
 rtl/shiftreg_shift_step.sv | 29 ++
 rtl/shiftreg_seq.sv | 158 +++++++++++++++
 tb/tb_shiftreg_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types for the shift register slice: shift modes and burst FSM states.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        SH_LR = 2'b00,
        SH_AR = 2'b01,
        SH_LL = 2'b10,
        SH_RR = 2'b11
    } shift_mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/shiftreg_shift_step.sv
// One-position combinational shift of a WIDTH-bit word; so is the bit that leaves the word.
module shift_step
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] d,
    input  shift_mode_e      mode,
    input  logic             sr_in,
    output logic [WIDTH-1:0] q,
    output logic             so
);

    always_comb begin
        q  = d;
        so = d[0];
        case (mode)
            SH_LR: q = {sr_in, d[WIDTH-1:1]};
            SH_AR: q = {d[WIDTH-1], d[WIDTH-1:1]};
            SH_LL: begin
                q  = {d[WIDTH-2:0], sr_in};
                so = d[WIDTH-1];
            end
            SH_RR: q = {d[0], d[WIDTH-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shiftreg_seq.sv
// Sequential shift register with parallel load, single shifts and self-timed bursts.
// Define SHIFTREG_STEP2_EN to add the step2 port (two positions per burst cycle).
module shiftreg_seq
    import shiftreg_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sft,
    input  logic [1:0]       mode,
    input  logic             sr_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
`ifdef SHIFTREG_STEP2_EN
    input  logic             step2,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             so,
    output logic             busy,
    output logic             done,
    output state_e           dbg_state
);

    state_e            state, state_n;
    logic [WIDTH-1:0]  data_q, data_n;
    logic              so_q, so_n;
    logic              done_q, done_n;
    logic [CNT_W-1:0]  rem_q, rem_n;
    shift_mode_e       mode_q, mode_n;
    shift_mode_e       step_mode;
    logic [WIDTH-1:0]  q1;
    logic              so1;
    logic [CNT_W-1:0]  count_clamped;

    assign count_clamped = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;
    // A burst uses the mode latched at start; single shifts use the live mode.
    assign step_mode     = (state == S_RUN) ? mode_q : shift_mode_e'(mode);

    shift_step #(.WIDTH(WIDTH)) u_step1 (
        .d     (data_q),
        .mode  (step_mode),
        .sr_in (sr_in),
        .q     (q1),
        .so    (so1)
    );

`ifdef SHIFTREG_STEP2_EN
    logic             step2_q, step2_n;
    logic [WIDTH-1:0] q2;
    logic             so2;

    shift_step #(.WIDTH(WIDTH)) u_step2 (
        .d     (q1),
        .mode  (step_mode),
        .sr_in (sr_in),
        .q     (q2),
        .so    (so2)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) step2_q <= 1'b0;
        else        step2_q <= step2_n;
    end
`endif

    always_comb begin
        state_n = state;
        data_n  = data_q;
        so_n    = so_q;
        rem_n   = rem_q;
        mode_n  = mode_q;
        done_n  = 1'b0;
`ifdef SHIFTREG_STEP2_EN
        step2_n = step2_q;
`endif
        case (state)
            S_IDLE: begin
                if (clr) begin
                    data_n = '0;
                    so_n   = 1'b0;
                    rem_n  = '0;
                end else if (ld) begin
                    data_n = data_in;
                end else if (start) begin
                    rem_n  = count_clamped;
                    mode_n = shift_mode_e'(mode);
`ifdef SHIFTREG_STEP2_EN
                    step2_n = step2;
`endif
                    if (count_clamped == '0) done_n  = 1'b1;
                    else                     state_n = S_RUN;
                end else if (sft) begin
                    data_n = q1;
                    so_n   = so1;
                end
            end
            S_RUN: begin
                if (clr) begin
                    state_n = S_IDLE;
                    data_n  = '0;
                    so_n    = 1'b0;
                    rem_n   = '0;
                end else begin
`ifdef SHIFTREG_STEP2_EN
                    if (step2_q && rem_q >= CNT_W'(2)) begin
                        data_n = q2;
                        so_n   = so2;
                        rem_n  = rem_q - CNT_W'(2);
                    end else begin
                        data_n = q1;
                        so_n   = so1;
                        rem_n  = rem_q - CNT_W'(1);
                    end
`else
                    data_n = q1;
                    so_n   = so1;
                    rem_n  = rem_q - CNT_W'(1);
`endif
                    if (rem_n == '0) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= S_IDLE;
            data_q <= '0;
            so_q   <= 1'b0;
            done_q <= 1'b0;
            rem_q  <= '0;
            mode_q <= SH_LR;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            so_q   <= so_n;
            done_q <= done_n;
            rem_q  <= rem_n;
            mode_q <= mode_n;
        end
    end

    assign data_out  = data_q;
    assign so        = so_q;
    assign busy      = (state == S_RUN);
    assign done      = done_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_shiftreg_seq.sv
// Directed table-driven bench for shiftreg_seq; step2 sequence runs when SHIFTREG_STEP2_EN is defined.
module tb_shiftreg_seq;
    import shiftreg_pkg::*;

    logic        clk;
    logic        clr_n;
    logic        clr;
    logic        ld;
    logic [15:0] data_in;
    logic        sft;
    logic [1:0]  mode;
    logic        sr_in;
    logic        start;
    logic [4:0]  count;
    logic        step2;
    logic [15:0] data_out;
    logic        so;
    logic        busy;
    logic        done;
    state_e      dbg_state;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic        clr;
        logic        ld;
        logic [15:0] din;
        logic        sft;
        logic [1:0]  mode;
        logic        sr;
        logic        start;
        logic [4:0]  cnt;
        logic [15:0] e_data;
        logic        e_so;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    shiftreg_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .clr       (clr),
        .ld        (ld),
        .data_in   (data_in),
        .sft       (sft),
        .mode      (mode),
        .sr_in     (sr_in),
        .start     (start),
        .count     (count),
`ifdef SHIFTREG_STEP2_EN
        .step2     (step2),
`endif
        .data_out  (data_out),
        .so        (so),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic c, logic l, logic [15:0] din, logic s,
                                logic [1:0] m, logic sr, logic st, logic [4:0] cnt,
                                logic [15:0] ed, logic eso, logic eb, logic edn);
        vec_t v;
        v.name = name; v.clr = c; v.ld = l; v.din = din; v.sft = s; v.mode = m; v.sr = sr;
        v.start = st; v.cnt = cnt; v.e_data = ed; v.e_so = eso; v.e_busy = eb; v.e_done = edn;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v);
        clr = v.clr; ld = v.ld; data_in = v.din; sft = v.sft; mode = v.mode;
        sr_in = v.sr; start = v.start; count = v.cnt;
        @(posedge clk);
        #1;
        chk({v.name, ".data"}, 32'(data_out), 32'(v.e_data));
        chk({v.name, ".so"},   32'(so),       32'(v.e_so));
        chk({v.name, ".busy"}, 32'(busy),     32'(v.e_busy));
        chk({v.name, ".done"}, 32'(done),     32'(v.e_done));
    endtask

    task automatic idle_inputs();
        clr = 0; ld = 0; data_in = '0; sft = 0; mode = 2'b00; sr_in = 0; start = 0; count = '0;
    endtask

    initial begin
        logic [15:0] rot;
        idle_inputs();
        step2 = 1'b0;
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.data", 32'(data_out), 32'h0);
        chk("reset.so",   32'(so),       32'h0);
        chk("reset.busy", 32'(busy),     32'h0);
        chk("reset.done", 32'(done),     32'h0);
        clr_n = 1'b1;

        //         name        clr ld din       sft mode  sr st cnt    data      so b  d
        vecs.push_back(mk("ld8001",  0, 1, 16'h8001, 0, 2'b00, 0, 0, 5'd0, 16'h8001, 0, 0, 0));
        vecs.push_back(mk("sft_ar",  0, 0, 16'h0000, 1, 2'b01, 0, 0, 5'd0, 16'hC000, 1, 0, 0));
        vecs.push_back(mk("ld00f0",  0, 1, 16'h00F0, 0, 2'b00, 0, 0, 5'd0, 16'h00F0, 1, 0, 0));
        vecs.push_back(mk("lr4_st",  0, 0, 16'h0000, 0, 2'b00, 0, 1, 5'd4, 16'h00F0, 1, 1, 0));
        vecs.push_back(mk("lr4_1",   0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h0078, 0, 1, 0));
        vecs.push_back(mk("lr4_2",   0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h003C, 0, 1, 0));
        vecs.push_back(mk("lr4_3",   0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h001E, 0, 1, 0));
        vecs.push_back(mk("lr4_4",   0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h000F, 0, 0, 1));
        vecs.push_back(mk("lr4_end", 0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h000F, 0, 0, 0));
        vecs.push_back(mk("ld0001",  0, 1, 16'h0001, 0, 2'b00, 0, 0, 5'd0, 16'h0001, 0, 0, 0));
        vecs.push_back(mk("rr20_st", 0, 0, 16'h0000, 0, 2'b11, 1, 1, 5'd20, 16'h0001, 0, 1, 0));
        // Live mode/sr_in differ from the latched burst mode to show the latch is used.
        for (int j = 1; j <= 16; j++) begin
            rot = (16'h0001 >> j) | (16'h0001 << (16 - j));
            vecs.push_back(mk($sformatf("rr20_%0d", j), 0, 0, 16'h0000, 0, 2'b00, 1, 0, 5'd0,
                              rot, (j == 1), (j < 16), (j == 16)));
        end
        vecs.push_back(mk("ll3_st",  0, 0, 16'h0000, 0, 2'b10, 1, 1, 5'd3, 16'h0001, 0, 1, 0));
        vecs.push_back(mk("ll3_1",   0, 0, 16'h0000, 0, 2'b00, 1, 0, 5'd0, 16'h0003, 0, 1, 0));
        vecs.push_back(mk("ll3_2",   0, 0, 16'h0000, 0, 2'b00, 1, 0, 5'd0, 16'h0007, 0, 1, 0));
        vecs.push_back(mk("ll3_3",   0, 0, 16'h0000, 0, 2'b00, 1, 0, 5'd0, 16'h000F, 0, 0, 1));
        vecs.push_back(mk("cnt0",    0, 0, 16'h0000, 0, 2'b00, 1, 1, 5'd0, 16'h000F, 0, 0, 1));
        vecs.push_back(mk("lr2_st",  0, 0, 16'h0000, 0, 2'b00, 1, 1, 5'd2, 16'h000F, 0, 1, 0));
        vecs.push_back(mk("lr2_1",   0, 0, 16'h0000, 0, 2'b00, 1, 0, 5'd0, 16'h8007, 1, 1, 0));
        vecs.push_back(mk("lr2_2",   0, 0, 16'h0000, 0, 2'b00, 1, 0, 5'd0, 16'hC003, 1, 0, 1));
        vecs.push_back(mk("ar4_st",  0, 0, 16'h0000, 0, 2'b01, 0, 1, 5'd4, 16'hC003, 1, 1, 0));
        vecs.push_back(mk("ar4_ign", 0, 1, 16'hFFFF, 1, 2'b10, 0, 1, 5'd1, 16'hE001, 1, 1, 0));
        vecs.push_back(mk("ar4_2",   0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'hF000, 1, 1, 0));
        vecs.push_back(mk("ar4_3",   0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'hF800, 0, 1, 0));
        vecs.push_back(mk("ar4_4",   0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'hFC00, 0, 0, 1));
        vecs.push_back(mk("ar4_end", 0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'hFC00, 0, 0, 0));
        vecs.push_back(mk("sft_ll",  0, 0, 16'h0000, 1, 2'b10, 1, 0, 5'd0, 16'hF801, 1, 0, 0));
        vecs.push_back(mk("ldffff",  0, 1, 16'hFFFF, 0, 2'b00, 0, 0, 5'd0, 16'hFFFF, 1, 0, 0));
        vecs.push_back(mk("clr8_st", 0, 0, 16'h0000, 0, 2'b00, 0, 1, 5'd8, 16'hFFFF, 1, 1, 0));
        vecs.push_back(mk("clr8_1",  0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h7FFF, 1, 1, 0));
        vecs.push_back(mk("clr8_2",  0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h3FFF, 1, 1, 0));
        vecs.push_back(mk("clr8_ab", 1, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("clr8_p1", 0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("clr8_p2", 0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h0000, 0, 0, 0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the third busy cycle of an 8-position burst.
        run_vec(mk("a_ld",  0, 1, 16'hFFFF, 0, 2'b00, 1, 0, 5'd0, 16'hFFFF, 0, 0, 0));
        run_vec(mk("a_st",  0, 0, 16'h0000, 0, 2'b00, 1, 1, 5'd8, 16'hFFFF, 0, 1, 0));
        run_vec(mk("a_1",   0, 0, 16'h0000, 0, 2'b00, 1, 0, 5'd0, 16'hFFFF, 1, 1, 0));
        run_vec(mk("a_2",   0, 0, 16'h0000, 0, 2'b00, 1, 0, 5'd0, 16'hFFFF, 1, 1, 0));
        idle_inputs();
        clr_n = 1'b0;
        #2;
        chk("async.data",  32'(data_out),  32'h0);
        chk("async.so",    32'(so),        32'h0);
        chk("async.busy",  32'(busy),      32'h0);
        chk("async.done",  32'(done),      32'h0);
        chk("async.state", 32'(dbg_state), 32'(S_IDLE));
        @(posedge clk);
        #1;
        chk("async_hold.data", 32'(data_out), 32'h0);
        clr_n = 1'b1;
        run_vec(mk("a_post", 0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'h0000, 0, 0, 0));
        run_vec(mk("a_ld2",  0, 1, 16'h1234, 0, 2'b00, 0, 0, 5'd0, 16'h1234, 0, 0, 0));

`ifdef SHIFTREG_STEP2_EN
        run_vec(mk("s2_ld", 0, 1, 16'h8000, 0, 2'b00, 0, 0, 5'd0, 16'h8000, 0, 0, 0));
        step2 = 1'b1;
        run_vec(mk("s2_st", 0, 0, 16'h0000, 0, 2'b01, 0, 1, 5'd5, 16'h8000, 0, 1, 0));
        step2 = 1'b0;
        run_vec(mk("s2_1",  0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'hE000, 0, 1, 0));
        run_vec(mk("s2_2",  0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'hF800, 0, 1, 0));
        run_vec(mk("s2_3",  0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'hFC00, 0, 0, 1));
        run_vec(mk("s2_end", 0, 0, 16'h0000, 0, 2'b00, 0, 0, 5'd0, 16'hFC00, 0, 0, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
